// File: rtl/montgomery_bitserial.sv
// Radix-2 bit-serial Montgomery multiplier: result = in_a * in_b * 2^-N mod in_m.
// One load edge, N loop edges, one final-subtraction edge per operation.
module montgomery_bitserial #(
  parameter int unsigned N  = 1024,
  parameter int unsigned CW = 10
) (
  input  logic         clk,
  input  logic         resetn,
  input  logic         start,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic [N-1:0] in_m,
  output logic [N-1:0] result,
  output logic         done,
  output logic         busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOOP = 2'd1,
    SUB  = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [N-1:0]  a_reg, a_reg_n;
  logic [N-1:0]  b_reg, b_reg_n;
  logic [N-1:0]  m_reg, m_reg_n;
  logic [N+1:0]  c_reg, c_reg_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [N-1:0]  result_n;
  logic          done_n, busy_n;

  // Iteration datapath; C stays below 2*m so N+2 bits never overflow.
  logic [N+1:0]  t_sum, u_sum, c_diff;

  always_comb begin
    t_sum  = c_reg + (a_reg[0] ? {2'b00, b_reg} : '0);
    u_sum  = t_sum + (t_sum[0] ? {2'b00, m_reg} : '0);
    c_diff = c_reg - {2'b00, m_reg};
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state  <= IDLE;
      a_reg  <= '0;
      b_reg  <= '0;
      m_reg  <= '0;
      c_reg  <= '0;
      cnt    <= '0;
      result <= '0;
      done   <= 1'b0;
      busy   <= 1'b0;
    end else begin
      state  <= state_n;
      a_reg  <= a_reg_n;
      b_reg  <= b_reg_n;
      m_reg  <= m_reg_n;
      c_reg  <= c_reg_n;
      cnt    <= cnt_n;
      result <= result_n;
      done   <= done_n;
      busy   <= busy_n;
    end
  end

  always_comb begin
    state_n  = state;
    a_reg_n  = a_reg;
    b_reg_n  = b_reg;
    m_reg_n  = m_reg;
    c_reg_n  = c_reg;
    cnt_n    = cnt;
    result_n = result;
    done_n   = 1'b0;
    busy_n   = busy;

    unique case (state)
      IDLE: begin
        if (start) begin
          a_reg_n = in_a;
          b_reg_n = in_b;
          m_reg_n = in_m;
          c_reg_n = '0;
          cnt_n   = '0;
          busy_n  = 1'b1;
          state_n = LOOP;
        end
      end
      LOOP: begin
        c_reg_n = u_sum >> 1;
        a_reg_n = a_reg >> 1;
        cnt_n   = cnt + 1'b1;
        if (cnt == CW'(N - 1)) state_n = SUB;
      end
      SUB: begin
        result_n = (c_reg >= {2'b00, m_reg}) ? c_diff[N-1:0] : c_reg[N-1:0];
        done_n   = 1'b1;
        busy_n   = 1'b0;
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
